seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 174 +++++++++++++++++
 tb/tb_seq_alu.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub/shift/logic ops plus iterative
// shift-add multiply and restoring divide, one bit per clock.
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  input  logic             CarryIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALU_Out,
  output logic [WIDTH-1:0] ALU_OutHi,
  output logic             CarryOut,
  output logic             Zero,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic [WIDTH-1:0] opb_reg, opb_next;
  logic [WIDTH-1:0] out_lo_reg, out_lo_next;
  logic [WIDTH-1:0] out_hi_reg, out_hi_next;
  logic             carry_reg, carry_next;
  logic             dbz_reg, dbz_next;
  logic             done_reg, done_next;

  logic [WIDTH:0]   add_sum, sub_diff, mul_sum, div_shift, div_trial;
  logic [WIDTH-1:0] mul_hi_step, mul_lo_step, div_hi_step, div_lo_step;

  assign add_sum  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, CarryIn};
  assign sub_diff = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, CarryIn};

  // Multiply: hi_reg is the accumulator, lo_reg the multiplier shifting out LSB-first.
  assign mul_sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opb_reg} : '0);
  assign mul_hi_step = mul_sum[WIDTH:1];
  assign mul_lo_step = {mul_sum[0], lo_reg[WIDTH-1:1]};

  // Divide: hi_reg is the partial remainder, lo_reg shifts dividend out / quotient in.
  // The shifted remainder never exceeds 2*B-1, so bit WIDTH of the trial is a true sign.
  assign div_shift   = {hi_reg, lo_reg[WIDTH-1]};
  assign div_trial   = div_shift - {1'b0, opb_reg};
  assign div_hi_step = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
  assign div_lo_step = {lo_reg[WIDTH-2:0], ~div_trial[WIDTH]};

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    opb_next    = opb_reg;
    out_lo_next = out_lo_reg;
    out_hi_next = out_hi_reg;
    carry_next  = carry_reg;
    dbz_next    = dbz_reg;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          opb_next = B;
          hi_next  = '0;
          lo_next  = A;
          cnt_next = '0;
          case (ALU_Sel)
            4'b0010: state_next = MUL;
            4'b0011: begin
              if (B == '0) begin
                out_lo_next = '1;
                out_hi_next = A;
                carry_next  = 1'b0;
                dbz_next    = 1'b1;
                done_next   = 1'b1;
              end else begin
                state_next = DIV;
              end
            end
            default: begin
              out_hi_next = '0;
              carry_next  = 1'b0;
              dbz_next    = 1'b0;
              done_next   = 1'b1;
              case (ALU_Sel)
                4'b0001: begin out_lo_next = sub_diff[WIDTH-1:0]; carry_next = sub_diff[WIDTH]; end
                4'b0100: begin out_lo_next = {A[WIDTH-2:0], 1'b0};      carry_next = A[WIDTH-1]; end
                4'b0101: begin out_lo_next = {1'b0, A[WIDTH-1:1]};      carry_next = A[0]; end
                4'b0110: begin out_lo_next = {A[WIDTH-2:0], A[WIDTH-1]}; carry_next = A[WIDTH-1]; end
                4'b0111: begin out_lo_next = {A[0], A[WIDTH-1:1]};      carry_next = A[0]; end
                4'b1000: out_lo_next = A & B;
                4'b1001: out_lo_next = A | B;
                4'b1010: out_lo_next = A ^ B;
                4'b1011: out_lo_next = ~(A | B);
                4'b1100: out_lo_next = ~(A & B);
                4'b1101: out_lo_next = ~(A ^ B);
                default: begin out_lo_next = add_sum[WIDTH-1:0]; carry_next = add_sum[WIDTH]; end
              endcase
            end
          endcase
        end
      end
      MUL: begin
        hi_next  = mul_hi_step;
        lo_next  = mul_lo_step;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == LAST) begin
          state_next  = IDLE;
          out_lo_next = mul_lo_step;
          out_hi_next = mul_hi_step;
          carry_next  = 1'b0;
          dbz_next    = 1'b0;
          done_next   = 1'b1;
        end
      end
      DIV: begin
        hi_next  = div_hi_step;
        lo_next  = div_lo_step;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == LAST) begin
          state_next  = IDLE;
          out_lo_next = div_lo_step;
          out_hi_next = div_hi_step;
          carry_next  = 1'b0;
          dbz_next    = 1'b0;
          done_next   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      opb_reg    <= '0;
      out_lo_reg <= '0;
      out_hi_reg <= '0;
      carry_reg  <= 1'b0;
      dbz_reg    <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      opb_reg    <= opb_next;
      out_lo_reg <= out_lo_next;
      out_hi_reg <= out_hi_next;
      carry_reg  <= carry_next;
      dbz_reg    <= dbz_next;
      done_reg   <= done_next;
    end
  end

  assign busy      = (state_reg == MUL) || (state_reg == DIV);
  assign done      = done_reg;
  assign ALU_Out   = out_lo_reg;
  assign ALU_OutHi = out_hi_reg;
  assign CarryOut  = carry_reg;
  assign DivByZero = dbz_reg;
  assign Zero      = (out_lo_reg == '0) && (out_hi_reg == '0);

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=16): expected results are queued at
// acceptance and compared, together with held outputs, on every falling edge.
module tb_seq_alu;
  localparam int W = 16;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         c;
    logic         dbz;
    int           lat;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic [3:0]   ALU_Sel = '0;
  logic         CarryIn = 1'b0;
  logic         busy, done, CarryOut, Zero, DivByZero;
  logic [W-1:0] ALU_Out, ALU_OutHi;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .ALU_Sel(ALU_Sel),
    .CarryIn(CarryIn), .busy(busy), .done(done), .ALU_Out(ALU_Out),
    .ALU_OutHi(ALU_OutHi), .CarryOut(CarryOut), .Zero(Zero), .DivByZero(DivByZero)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   ready_cyc = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;
  bit   chk_en = 1'b0;
  exp_t sb_q[$];
  exp_t held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] sel, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic cin);
    exp_t r;
    logic [2*W-1:0] p;
    logic [W:0]     s;
    r.lo = '0; r.hi = '0; r.c = 1'b0; r.dbz = 1'b0; r.lat = 1; r.due = 0;
    case (sel)
      4'd1: begin
        r.lo = a - b - W'(cin);
        r.c  = ({1'b0, a} < ({1'b0, b} + (W + 1)'(cin)));
      end
      4'd2: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        r.lo = p[W-1:0]; r.hi = p[2*W-1:W]; r.lat = W + 1;
      end
      4'd3: begin
        if (b == 0) begin r.lo = '1; r.hi = a; r.dbz = 1'b1; end
        else begin r.lo = a / b; r.hi = a % b; r.lat = W + 1; end
      end
      4'd4: begin r.lo = a << 1; r.c = a[W-1]; end
      4'd5: begin r.lo = a >> 1; r.c = a[0]; end
      4'd6: begin r.lo = (a << 1) | (a >> (W - 1)); r.c = a[W-1]; end
      4'd7: begin r.lo = (a >> 1) | (a << (W - 1)); r.c = a[0]; end
      4'd8:  r.lo = a & b;
      4'd9:  r.lo = a | b;
      4'd10: r.lo = a ^ b;
      4'd11: r.lo = ~(a | b);
      4'd12: r.lo = ~(a & b);
      4'd13: r.lo = ~(a ^ b);
      default: begin
        s = a + b + cin;
        r.lo = s[W-1:0]; r.c = s[W];
      end
    endcase
    return r;
  endfunction

  // Compare every output against the scoreboard on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_done;
      exp_done = (sb_q.size() > 0) && (sb_q[0].due == cyc);
      if (exp_done) begin
        held = sb_q.pop_front();
        $display("cycle %0d: done lo=%h hi=%h c=%b dbz=%b", cyc, ALU_Out, ALU_OutHi, CarryOut, DivByZero);
      end
      check("done", done, exp_done);
      check("busy", busy, (cyc >= busy_lo) && (cyc <= busy_hi));
      check("ALU_Out", ALU_Out, held.lo);
      check("ALU_OutHi", ALU_OutHi, held.hi);
      check("CarryOut", CarryOut, held.c);
      check("DivByZero", DivByZero, held.dbz);
      check("Zero", Zero, (held.lo == 0) && (held.hi == 0));
    end
  end

  task automatic try_op(input logic [3:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, output bit acc);
    exp_t e;
    start = 1'b1; ALU_Sel = sel; A = a; B = b; CarryIn = cin;
    acc = (cyc >= ready_cyc);
    if (acc) begin
      e = model(sel, a, b, cin);
      e.due = cyc + e.lat;
      ready_cyc = e.due;
      if (e.lat > 1) begin busy_lo = cyc + 1; busy_hi = e.due - 1; end
      sb_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 64 && !acc; i++) try_op(sel, a, b, cin, acc);
    if (!acc) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: op %0d never accepted (cycle %0d)", sel, cyc);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 64 && sb_q.size() > 0; i++) @(negedge clk);
    check("drain", sb_q.size(), 0);
  endtask

  // Holds rst with a pending start request, which must have no effect.
  task automatic do_reset(input int n);
    chk_en = 1'b0;
    rst = 1'b1; start = 1'b1; ALU_Sel = 4'd0; A = 16'h0005; B = 16'h0005; CarryIn = 1'b1;
    repeat (n) begin
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
    end
    check("rst_ALU_Out", ALU_Out, 0);
    check("rst_ALU_OutHi", ALU_OutHi, 0);
    check("rst_CarryOut", CarryOut, 0);
    check("rst_DivByZero", DivByZero, 0);
    check("rst_Zero", Zero, 1);
    sb_q.delete();
    held = '{lo: '0, hi: '0, c: 1'b0, dbz: 1'b0, lat: 0, due: 0};
    busy_lo = 1; busy_hi = 0; ready_cyc = cyc;
    start = 1'b0; rst = 1'b0; chk_en = 1'b1;
  endtask

  initial begin
    bit acc;
    do_reset(3);

    run_op(4'd0, 16'hFFFF, 16'h0001, 1'b0);
    wait_drain();
    check("add_lo", ALU_Out, 16'h0000);
    check("add_carry", CarryOut, 1);
    check("add_zero", Zero, 1);

    run_op(4'd1, 16'h0003, 16'h0005, 1'b1);
    wait_drain();
    check("sub_lo", ALU_Out, 16'hFFFD);
    check("sub_borrow", CarryOut, 1);

    run_op(4'd2, 16'hFFFF, 16'hFFFF, 1'b0);
    repeat (3) try_op(4'd9, W'($urandom), W'($urandom), 1'b1, acc);
    wait_drain();
    check("mul_hi", ALU_OutHi, 16'hFFFE);
    check("mul_lo", ALU_Out, 16'h0001);

    run_op(4'd3, 16'h0064, 16'h0007, 1'b0);
    wait_drain();
    check("div_q", ALU_Out, 16'h000E);
    check("div_r", ALU_OutHi, 16'h0002);

    run_op(4'd3, 16'h1234, 16'h0000, 1'b0);
    wait_drain();
    check("div0_lo", ALU_Out, 16'hFFFF);
    check("div0_hi", ALU_OutHi, 16'h1234);
    check("div0_flag", DivByZero, 1);

    run_op(4'd2, 16'h1234, 16'h5678, 1'b0);
    repeat (4) @(negedge clk);
    do_reset(2);
    run_op(4'd0, 16'h0010, 16'h0020, 1'b1);
    wait_drain();
    check("add_after_rst", ALU_Out, 16'h0031);

    for (int s = 0; s < 16; s++) run_op(4'(s), W'($urandom), W'($urandom_range(1, 65535)), 1'($urandom));
    wait_drain();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0)
        try_op(4'($urandom), W'($urandom), ($urandom_range(0, 7) == 0) ? '0 : W'($urandom),
               1'($urandom), acc);
      else
        @(negedge clk);
    end
    wait_drain();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
